// File: rtl/bip_pkg.sv
// bip_pkg: shared widths, opcodes, mux encodings and state type for the BIP control unit
package bip_pkg;
  localparam int DEF_OPC_W = 5;
  localparam int DEF_ADDR_W = 11;
  localparam int DEF_INSTR_W = 16;
  localparam logic [4:0] OPC_HLT  = 5'b00000;
  localparam logic [4:0] OPC_STO  = 5'b00001;
  localparam logic [4:0] OPC_LD   = 5'b00010;
  localparam logic [4:0] OPC_LDI  = 5'b00011;
  localparam logic [4:0] OPC_ADD  = 5'b00100;
  localparam logic [4:0] OPC_ADDI = 5'b00101;
  localparam logic [4:0] OPC_SUB  = 5'b00110;
  localparam logic [4:0] OPC_SUBI = 5'b00111;
  localparam logic [1:0] SELA_RAM = 2'b00;
  localparam logic [1:0] SELA_IMM = 2'b01;
  localparam logic [1:0] SELA_ALU = 2'b10;
  localparam logic SELB_RAM = 1'b0;
  localparam logic SELB_IMM = 1'b1;
  typedef enum logic {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_t;
endpackage

// File: rtl/bip_decoder.sv
// bip_decoder: combinational opcode-to-strobe mapping with HLT and illegal-opcode flags
module bip_decoder
  import bip_pkg::*;
#(
  parameter int OPC_W = DEF_OPC_W
) (
  input  logic [OPC_W-1:0] opc,
  output logic             op,
  output logic [1:0]       sel_a,
  output logic             sel_b,
  output logic             wr_acc,
  output logic             wr_ram,
  output logic             rd_ram,
  output logic             is_hlt,
  output logic             illegal
);
  always_comb begin
    op = 1'b0;
    sel_a = SELA_RAM;
    sel_b = SELB_RAM;
    wr_acc = 1'b0;
    wr_ram = 1'b0;
    rd_ram = 1'b0;
    is_hlt = 1'b0;
    illegal = 1'b0;
    case (opc)
      OPC_HLT: is_hlt = 1'b1;
      OPC_STO: wr_ram = 1'b1;
      OPC_LD: begin
        rd_ram = 1'b1;
        wr_acc = 1'b1;
      end
      OPC_LDI: begin
        sel_a = SELA_IMM;
        wr_acc = 1'b1;
      end
      OPC_ADD, OPC_SUB: begin
        rd_ram = 1'b1;
        op = (opc == OPC_ADD);
        sel_a = SELA_ALU;
        wr_acc = 1'b1;
      end
      OPC_ADDI, OPC_SUBI: begin
        sel_b = SELB_IMM;
        op = (opc == OPC_ADDI);
        sel_a = SELA_ALU;
        wr_acc = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/bip_control.sv
// bip_control: BIP program counter, run/halt state and qualified datapath strobes.
// Define BIP_CYCLE_COUNT_EN to add a saturating 32-bit cycle_count output.
module bip_control
  import bip_pkg::*;
#(
  parameter int OPC_W = DEF_OPC_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic [ADDR_W-1:0]  pc_addr,
  output logic [ADDR_W-1:0]  operand,
  output logic               op,
  output logic [1:0]         sel_a,
  output logic               sel_b,
  output logic               wr_acc,
  output logic               wr_ram,
  output logic               rd_ram,
  output logic               halted,
  output logic               illegal
`ifdef BIP_CYCLE_COUNT_EN
  ,
  output logic [31:0]        cycle_count
`endif
);
  state_t state;
  logic go;
  logic d_op, d_sel_b, d_wr_acc, d_wr_ram, d_rd_ram, d_hlt, d_illegal;
  logic [1:0] d_sel_a;
  bip_decoder #(.OPC_W(OPC_W)) u_dec (
    .opc(instr[INSTR_W-1 -: OPC_W]),
    .op(d_op),
    .sel_a(d_sel_a),
    .sel_b(d_sel_b),
    .wr_acc(d_wr_acc),
    .wr_ram(d_wr_ram),
    .rd_ram(d_rd_ram),
    .is_hlt(d_hlt),
    .illegal(d_illegal)
  );
  // reset also gates strobes so nothing writes while the core is being reset
  assign go = (state == ST_RUN) && instr_valid && !reset;
  assign operand = instr[ADDR_W-1:0];
  assign op = go && d_op;
  assign sel_a = go ? d_sel_a : SELA_RAM;
  assign sel_b = go ? d_sel_b : SELB_RAM;
  assign wr_acc = go && d_wr_acc;
  assign wr_ram = go && d_wr_ram;
  assign rd_ram = go && d_rd_ram;
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_addr <= '0;
      state <= ST_RUN;
      halted <= 1'b0;
      illegal <= 1'b0;
    end else begin
      illegal <= go && d_illegal;
      if (go && d_hlt) begin
        state <= ST_HALTED;
        halted <= 1'b1;
      end else if (go) begin
        pc_addr <= pc_addr + ADDR_W'(1);
      end
    end
  end
`ifdef BIP_CYCLE_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) cycle_count <= '0;
    else if (state == ST_RUN && cycle_count != '1) cycle_count <= cycle_count + 32'd1;
  end
`endif
endmodule

// File: tb/tb_bip_control.sv
// tb_bip_control: scoreboard bench for bip_control; each step queues its stimulus
// with the expected output vector, and the entry is popped and compared mid-cycle.
module tb_bip_control;
  localparam logic [4:0] T_HLT = 5'd0, T_STO = 5'd1, T_LD = 5'd2, T_LDI = 5'd3;
  localparam logic [4:0] T_ADD = 5'd4, T_ADDI = 5'd5, T_SUB = 5'd6, T_BAD = 5'b11111;
  typedef struct {
    string       name;
    logic [15:0] instr;
    logic        valid;
    logic        rst;
    logic [30:0] exp;
    int          cnt;
  } stim_t;
  logic clk = 1'b0;
  logic reset, instr_valid;
  logic [15:0] instr;
  logic [10:0] pc_addr, operand;
  logic op, sel_b, wr_acc, wr_ram, rd_ram, halted, illegal;
  logic [1:0] sel_a;
  int checks = 0;
  int failures = 0;
  stim_t sb[$];
  stim_t s;
  wire [30:0] obs = {pc_addr, operand, op, sel_a, sel_b, wr_acc, wr_ram, rd_ram, halted, illegal};
`ifdef BIP_CYCLE_COUNT_EN
  logic [31:0] cycle_count;
`endif

  bip_control dut (
    .clk(clk),
    .reset(reset),
    .instr(instr),
    .instr_valid(instr_valid),
    .pc_addr(pc_addr),
    .operand(operand),
    .op(op),
    .sel_a(sel_a),
    .sel_b(sel_b),
    .wr_acc(wr_acc),
    .wr_ram(wr_ram),
    .rd_ram(rd_ram),
    .halted(halted),
    .illegal(illegal)
`ifdef BIP_CYCLE_COUNT_EN
    ,
    .cycle_count(cycle_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ins(input logic [4:0] o, input logic [10:0] a);
    return {o, a};
  endfunction

  function automatic logic [30:0] ev(input logic [10:0] pc, input logic [10:0] opr, input logic o,
                                     input logic [1:0] sa, input logic sbm, input logic wa,
                                     input logic wr, input logic rr, input logic h, input logic il);
    return {pc, opr, o, sa, sbm, wa, wr, rr, h, il};
  endfunction

  task automatic push(input string n, input logic [15:0] i, input logic v, input logic r,
                      input logic [30:0] e, input int c = -1);
    sb.push_back('{n, i, v, r, e, c});
  endtask

  task automatic test_reset();
    push("reset_state", ins(T_LDI, 11'd5), 1'b1, 1'b1, ev(11'd0, 11'd5, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    while (sb.size() > 0) begin
      s = sb.pop_front();
      instr = s.instr; instr_valid = s.valid; reset = s.rst;
      @(negedge clk);
      checks++;
      if (obs !== s.exp) begin failures++; $display("FAIL %s got=%h exp=%h", s.name, obs, s.exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_program();
    push("ldi5", ins(T_LDI, 11'd5), 1, 0, ev(11'd0, 11'd5, 0, 2'b01, 0, 1, 0, 0, 0, 0));
    push("addi3", ins(T_ADDI, 11'd3), 1, 0, ev(11'd1, 11'd3, 1, 2'b10, 1, 1, 0, 0, 0, 0));
    push("sto7", ins(T_STO, 11'd7), 1, 0, ev(11'd2, 11'd7, 0, 2'b00, 0, 0, 1, 0, 0, 0));
    push("hlt", ins(T_HLT, 11'd0), 1, 0, ev(11'd3, 11'd0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    push("halted1", ins(T_ADD, 11'd9), 1, 0, ev(11'd3, 11'd9, 0, 2'b00, 0, 0, 0, 0, 1, 0));
    push("halted2", ins(T_LDI, 11'd1), 1, 0, ev(11'd3, 11'd1, 0, 2'b00, 0, 0, 0, 0, 1, 0));
    push("rst_after_hlt", ins(T_LDI, 11'd1), 1, 1, ev(11'd3, 11'd1, 0, 2'b00, 0, 0, 0, 0, 1, 0));
    push("post_hlt_rst", ins(T_LDI, 11'd2), 1, 0, ev(11'd0, 11'd2, 0, 2'b01, 0, 1, 0, 0, 0, 0));
    while (sb.size() > 0) begin
      s = sb.pop_front();
      instr = s.instr; instr_valid = s.valid; reset = s.rst;
      @(negedge clk);
      checks++;
      if (obs !== s.exp) begin failures++; $display("FAIL %s got=%h exp=%h", s.name, obs, s.exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sub_and_stall();
    for (int k = 1; k < 10; k++)
      push("run_to_10", ins(T_LDI, 11'(k)), 1, 0, ev(11'(k), 11'(k), 0, 2'b01, 0, 1, 0, 0, 0, 0));
    push("sub12", ins(T_SUB, 11'd12), 1, 0, ev(11'd10, 11'd12, 0, 2'b10, 0, 1, 0, 1, 0, 0));
    for (int k = 0; k < 3; k++)
      push("stall", ins(T_ADD, 11'd4), 0, 0, ev(11'd11, 11'd4, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    push("resume_ld", ins(T_LD, 11'd4), 1, 0, ev(11'd11, 11'd4, 0, 2'b00, 0, 1, 0, 1, 0, 0));
    push("after_resume", ins(T_ADDI, 11'd1), 1, 0, ev(11'd12, 11'd1, 1, 2'b10, 1, 1, 0, 0, 0, 0));
    while (sb.size() > 0) begin
      s = sb.pop_front();
      instr = s.instr; instr_valid = s.valid; reset = s.rst;
      @(negedge clk);
      checks++;
      if (obs !== s.exp) begin failures++; $display("FAIL %s got=%h exp=%h", s.name, obs, s.exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    push("rst_at_13", ins(T_LDI, 11'd0), 1, 1, ev(11'd13, 11'd0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 6; k++)
      push("run_to_6", ins(T_LDI, 11'(k)), 1, 0, ev(11'(k), 11'(k), 0, 2'b01, 0, 1, 0, 0, 0, 0));
    push("rst_at_6", ins(T_ADD, 11'd6), 1, 1, ev(11'd6, 11'd6, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    push("post_mid_rst", ins(T_LDI, 11'd3), 1, 0, ev(11'd0, 11'd3, 0, 2'b01, 0, 1, 0, 0, 0, 0));
    while (sb.size() > 0) begin
      s = sb.pop_front();
      instr = s.instr; instr_valid = s.valid; reset = s.rst;
      @(negedge clk);
      checks++;
      if (obs !== s.exp) begin failures++; $display("FAIL %s got=%h exp=%h", s.name, obs, s.exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal_wrap();
    for (int k = 1; k < 2047; k++)
      push("run_to_2047", ins(T_LDI, 11'(k)), 1, 0, ev(11'(k), 11'(k), 0, 2'b01, 0, 1, 0, 0, 0, 0));
    push("illegal_op", ins(T_BAD, 11'd0), 1, 0, ev(11'd2047, 11'd0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    push("wrap_pulse", ins(T_LDI, 11'd1), 1, 0, ev(11'd0, 11'd1, 0, 2'b01, 0, 1, 0, 0, 0, 1));
    push("pulse_clear", ins(T_LDI, 11'd2), 1, 0, ev(11'd1, 11'd2, 0, 2'b01, 0, 1, 0, 0, 0, 0));
    while (sb.size() > 0) begin
      s = sb.pop_front();
      instr = s.instr; instr_valid = s.valid; reset = s.rst;
      @(negedge clk);
      checks++;
      if (obs !== s.exp) begin failures++; $display("FAIL %s got=%h exp=%h", s.name, obs, s.exp); end
      @(posedge clk); #1;
    end
  endtask

`ifdef BIP_CYCLE_COUNT_EN
  task automatic test_cycle_count();
    push("cc_rst", ins(T_LDI, 11'd0), 1, 1, ev(11'd2, 11'd0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    push("cc_ldi", ins(T_LDI, 11'd5), 1, 0, ev(11'd0, 11'd5, 0, 2'b01, 0, 1, 0, 0, 0, 0), 0);
    push("cc_addi", ins(T_ADDI, 11'd3), 1, 0, ev(11'd1, 11'd3, 1, 2'b10, 1, 1, 0, 0, 0, 0), 1);
    push("cc_stall1", ins(T_STO, 11'd7), 0, 0, ev(11'd2, 11'd7, 0, 2'b00, 0, 0, 0, 0, 0, 0), 2);
    push("cc_stall2", ins(T_STO, 11'd7), 0, 0, ev(11'd2, 11'd7, 0, 2'b00, 0, 0, 0, 0, 0, 0), 3);
    push("cc_sto", ins(T_STO, 11'd7), 1, 0, ev(11'd2, 11'd7, 0, 2'b00, 0, 0, 1, 0, 0, 0), 4);
    push("cc_hlt", ins(T_HLT, 11'd0), 1, 0, ev(11'd3, 11'd0, 0, 2'b00, 0, 0, 0, 0, 0, 0), 5);
    push("cc_halted1", ins(T_LDI, 11'd0), 1, 0, ev(11'd3, 11'd0, 0, 2'b00, 0, 0, 0, 0, 1, 0), 6);
    push("cc_halted2", ins(T_LDI, 11'd0), 0, 0, ev(11'd3, 11'd0, 0, 2'b00, 0, 0, 0, 0, 1, 0), 6);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      instr = s.instr; instr_valid = s.valid; reset = s.rst;
      @(negedge clk);
      checks++;
      if (obs !== s.exp) begin failures++; $display("FAIL %s got=%h exp=%h", s.name, obs, s.exp); end
      if (s.cnt >= 0) begin
        checks++;
        if (cycle_count !== 32'(s.cnt)) begin
          failures++;
          $display("FAIL %s_count got=%0d exp=%0d", s.name, cycle_count, s.cnt);
        end
      end
      @(posedge clk); #1;
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    @(posedge clk); #1;
    test_reset();
    test_program();
    test_sub_and_stall();
    test_reset_mid();
    test_illegal_wrap();
`ifdef BIP_CYCLE_COUNT_EN
    test_cycle_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bip_control.md
Name: bip_control

Overview:
- Control unit of the BIP accumulator processor: owns the program counter and decodes each fetched instruction into datapath strobes.
- It is the producer of the arithmetic unit's Op select (1 = ADD, 0 = SUB); it also drives the accumulator and data-RAM control signals.
- Sits between program memory (instruction source) and the accumulator/arithmetic-unit/data-RAM datapath.

Parameters:
- OPC_W, 5: opcode field width (instr[15:11]).
- ADDR_W, 11: PC and operand field width (instr[10:0]).
- INSTR_W, 16: instruction width; must equal OPC_W+ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- instr  in  INSTR_W  instruction word at address pc_addr.
- instr_valid  in  1  instr is valid this cycle; low = stall.
- pc_addr  out  ADDR_W  program counter, drives program-memory address.
- operand  out  ADDR_W  instr[10:0]; RAM address or immediate.
- op  out  1  arithmetic select: 1 = ADD, 0 = SUB.
- sel_a  out  2  accumulator input mux: 00 = RAM data, 01 = immediate, 10 = ALU result.
- sel_b  out  1  ALU B mux: 0 = RAM data, 1 = immediate.
- wr_acc  out  1  accumulator write enable.
- wr_ram  out  1  data-RAM write enable.
- rd_ram  out  1  data-RAM read enable.
- halted  out  1  core stopped on HLT.
- illegal  out  1  one-cycle pulse on an undefined opcode.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset: pc_addr = 0, state = RUN, halted = 0, illegal = 0. All strobes (wr_acc, wr_ram, rd_ram) are 0 while reset is high. Reset asserted mid-program takes effect on the next edge and overrides every other event.
- States:
  - RUN: fetch and execute.
  - HALTED: terminal state; left only by reset.
- Decode (combinational from instr, qualified by state == RUN && instr_valid; otherwise all strobes 0, op = 0, sel_a = 00, sel_b = 0):
  - 00000 HLT: no strobes.
  - 00001 STO: wr_ram = 1.
  - 00010 LD: rd_ram = 1, sel_a = 00, wr_acc = 1.
  - 00011 LDI: sel_a = 01, wr_acc = 1.
  - 00100 ADD: rd_ram = 1, sel_b = 0, op = 1, sel_a = 10, wr_acc = 1.
  - 00101 ADDI: sel_b = 1, op = 1, sel_a = 10, wr_acc = 1.
  - 00110 SUB: as ADD with op = 0.
  - 00111 SUBI: as ADDI with op = 0.
  - others: no strobes; illegal = 1 (registered, asserted the following cycle for one cycle).
- operand = instr[10:0] at all times, unqualified.
- Latency: single-cycle execute. Strobes are valid in the same cycle as instr; the PC updates on that cycle's edge.
- PC update at the edge, when RUN && instr_valid:
  - HLT: PC holds, state -> HALTED, halted = 1 from the next cycle.
  - any other opcode, including illegal: PC = PC + 1 modulo 2^ADDR_W (2047 wraps to 0, no flag).
- instr_valid = 0: PC and state hold; no strobes.
- HALTED: PC frozen on the HLT address; instr and instr_valid ignored; halted stays 1.

Optional Feature:
- Macro: BIP_CYCLE_COUNT_EN.
- Defined: adds output cycle_count (32 bits).
  - Cleared by reset.
  - Increments every clock while state == RUN, including stall cycles.
  - Frozen once HALTED; saturates at 0xFFFFFFFF.
  - Used to report execution time.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package bip_pkg holds:
  - opcode localparams (OPC_HLT … OPC_SUBI);
  - sel_a encodings (SELA_RAM, SELA_IMM, SELA_ALU) and sel_b encodings;
  - state encoding (ST_RUN, ST_HALTED);
  - default widths.
- One sub-module: bip_decoder, purely combinational, mapping opcode to strobes plus an illegal flag. bip_control keeps the PC, state register, qualification gating and the optional counter.

Test Plan:
- Reset with instr_valid = 1 and program LDI 5; ADDI 3; STO 7; HLT at addresses 0–3 -> the cycles show wr_acc, wr_acc with op = 1 and sel_b = 1, wr_ram with operand = 7, then halted = 1 with pc_addr = 3 thereafter.
- SUB 12 at PC 10 -> rd_ram = 1, op = 0, sel_a = 10, wr_acc = 1, operand = 12; PC = 11 next cycle.
- instr_valid low for 3 cycles mid-program -> pc_addr constant and all strobes 0; execution resumes unchanged when it rises.
- Opcode 11111 at PC 2047 -> illegal pulses for exactly one cycle, no strobes, pc_addr wraps to 0.
- reset asserted the cycle after HLT, and separately mid-program at PC 6 -> pc_addr = 0, halted = 0, state RUN on the next cycle.
- With BIP_CYCLE_COUNT_EN: 4-instruction program plus 2 stall cycles -> cycle_count = 6 at HLT, and it stays 6 while halted.
